// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter that shares one main-memory port between an
// instruction read port (i_*) and a data read/write port (d_*).
// Each granted access drives the memory for ACCESS_CYCLES cycles. It then
// captures the read data and pulses the owner's ack for one cycle in DONE.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   i_req/i_addr           instruction read request and address
//   i_ack/i_rdata          instruction completion pulse and registered data
//   d_req/d_we/d_addr/d_wdata  data request, direction, address, write data
//   d_ack/d_rdata          data completion pulse and registered read data
//   mem_addr/mem_re/mem_we/mem_wdata  main-memory strobes (only in BUSY)
//   mem_rdata              combinational read data from main memory
//   busy                   high while in BUSY or DONE
module mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic              r_owner_d;   // 1 = data port owns the current access
  logic              r_last_d;    // 1 = data port won the most recent grant
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_grant_d;
  logic              w_mem_we;

  // Arbitration: on a tie the port that did not win last time gets it.
  always_comb begin
    w_any_req = i_req | d_req;
    if (i_req && d_req) begin
      w_grant_d = ~r_last_d;
    end else begin
      w_grant_d = d_req;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: the memory bus is driven only while BUSY.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    w_mem_we  = 1'b0;
    mem_re    = 1'b0;
    if (r_state == S_BUSY) begin
      mem_addr  = r_owner_d ? d_addr : i_addr;
      w_mem_we  = r_owner_d & d_we;
      mem_re    = ~w_mem_we;
      mem_wdata = d_wdata;
    end
    mem_we = w_mem_we;
    busy   = (r_state != S_IDLE);
  end

  // Datapath: access counter, ownership, acks and read-data capture.
  // The acks are set on the BUSY->DONE edge, so they are high only in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b1;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_cnt     <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (r_owner_d) begin
            r_d_ack <= 1'b1;
            if (!w_mem_we) r_d_rdata <= mem_rdata;
          end else begin
            r_i_ack   <= 1'b1;
            r_i_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: DUT 0 uses ACCESS_CYCLES=1 and DUT 1 uses
// ACCESS_CYCLES=4. Each has its own behavioural memory. Single accesses come
// from a vector table. Round-robin and mid-access reset have their own
// hand-written sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_s    [2];
  logic        i_req_s    [2];
  logic [7:0]  i_addr_s   [2];
  logic        i_ack_o    [2];
  logic [31:0] i_rdata_o  [2];
  logic        d_req_s    [2];
  logic        d_we_s     [2];
  logic [7:0]  d_addr_s   [2];
  logic [31:0] d_wdata_s  [2];
  logic        d_ack_o    [2];
  logic [31:0] d_rdata_o  [2];
  logic [7:0]  mem_addr_o [2];
  logic        mem_re_o   [2];
  logic        mem_we_o   [2];
  logic [31:0] mem_wdata_o[2];
  logic [31:0] mem_rdata_s[2];
  logic        busy_o     [2];

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .ACCESS_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n_s[0]),
    .i_req(i_req_s[0]), .i_addr(i_addr_s[0]), .i_ack(i_ack_o[0]), .i_rdata(i_rdata_o[0]),
    .d_req(d_req_s[0]), .d_we(d_we_s[0]), .d_addr(d_addr_s[0]), .d_wdata(d_wdata_s[0]),
    .d_ack(d_ack_o[0]), .d_rdata(d_rdata_o[0]),
    .mem_addr(mem_addr_o[0]), .mem_re(mem_re_o[0]), .mem_we(mem_we_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_s[0]), .busy(busy_o[0])
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .ACCESS_CYCLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n_s[1]),
    .i_req(i_req_s[1]), .i_addr(i_addr_s[1]), .i_ack(i_ack_o[1]), .i_rdata(i_rdata_o[1]),
    .d_req(d_req_s[1]), .d_we(d_we_s[1]), .d_addr(d_addr_s[1]), .d_wdata(d_wdata_s[1]),
    .d_ack(d_ack_o[1]), .d_rdata(d_rdata_o[1]),
    .mem_addr(mem_addr_o[1]), .mem_re(mem_re_o[1]), .mem_we(mem_we_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_s[1]), .busy(busy_o[1])
  );

  // Behavioural memories: combinational read, write on the clock edge.
  // Known contents are reloaded while each DUT is held in reset.
  assign mem_rdata_s[0] = mem0[mem_addr_o[0]];
  assign mem_rdata_s[1] = mem1[mem_addr_o[1]];

  always @(posedge clk) begin
    if (!rst_n_s[0]) begin
      mem0[8'h10] <= 32'hA5A5A5A5;
      mem0[8'h20] <= 32'h00000000;
      mem0[8'h30] <= 32'hDEADBEEF;
    end else if (mem_we_o[0]) begin
      mem0[mem_addr_o[0]] <= mem_wdata_o[0];
    end
  end

  always @(posedge clk) begin
    if (!rst_n_s[1]) begin
      mem1[8'h40] <= 32'hCAFEF00D;
      mem1[8'h44] <= 32'h11112222;
    end else if (mem_we_o[1]) begin
      mem1[mem_addr_o[1]] <= mem_wdata_o[1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE to ack, checking latency, strobes and data.
  task automatic access(input int k, input bit port_d, input bit we,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int ac, input string name);
    int n = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    int both = 0;
    int first_s = -1;
    int last_s = -1;
    bit got = 0;
    bit wrong_ack = 0;
    logic [31:0] idle_bus;
    logic [31:0] rdata;
    tick();
    if (port_d) begin
      d_req_s[k] = 1'b1; d_we_s[k] = we; d_addr_s[k] = addr; d_wdata_s[k] = wdata;
    end else begin
      i_req_s[k] = 1'b1; i_addr_s[k] = addr;
    end
    while (n < 40 && !got) begin
      tick();
      n++;
      if (mem_re_o[k] || mem_we_o[k]) begin
        if (first_s < 0) first_s = n;
        last_s = n;
      end
      if (mem_re_o[k]) re_cnt++;
      if (mem_we_o[k]) we_cnt++;
      if (mem_re_o[k] && mem_we_o[k]) both++;
      if (port_d ? d_ack_o[k] : i_ack_o[k]) got = 1;
      if (port_d ? i_ack_o[k] : d_ack_o[k]) wrong_ack = 1;
    end
    idle_bus = {23'd0, mem_re_o[k], mem_addr_o[k]} | mem_wdata_o[k] | {31'd0, mem_we_o[k]};
    rdata = port_d ? d_rdata_o[k] : i_rdata_o[k];
    i_req_s[k] = 1'b0;
    d_req_s[k] = 1'b0;
    check({name, "_ack_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(ac + 1));
    check({name, "_re_cycles"}, 32'(re_cnt), we ? 32'd0 : 32'(ac));
    check({name, "_we_cycles"}, 32'(we_cnt), we ? 32'(ac) : 32'd0);
    check({name, "_strobe_span"}, 32'(last_s - first_s + 1), 32'(ac));
    check({name, "_re_we_overlap"}, 32'(both), 32'd0);
    check({name, "_other_ack"}, 32'(wrong_ack), 32'd0);
    check({name, "_bus_idle_in_done"}, idle_bus, 32'd0);
    check({name, "_rdata"}, rdata, exp_rdata);
    tick();
    check({name, "_ack_one_cycle"}, 32'(port_d ? d_ack_o[k] : i_ack_o[k]), 32'd0);
    $display("txn %s: dut%0d port=%s we=%0d addr=0x%02h latency=%0d rdata=0x%08h",
             name, k, port_d ? "D" : "I", we, addr, n, rdata);
  endtask

  typedef struct {
    bit          port_d;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // owner's rdata register after the access
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ord[4];
    int t_ack[4];
    logic [31:0] rd[4];
    int n_ack;
    int n;
    int stray;

    for (int k = 0; k < 2; k++) begin
      rst_n_s[k] = 1'b0; i_req_s[k] = 1'b0; d_req_s[k] = 1'b0; d_we_s[k] = 1'b0;
      i_addr_s[k] = '0; d_addr_s[k] = '0; d_wdata_s[k] = '0;
    end

    vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hA5A5A5A5};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 8'h20, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 8'h30, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b1, 8'h30, 32'h0BADF00D, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b0, 8'h30, 32'h0,        32'h0BADF00D};

    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_i_ack", k), 32'(i_ack_o[k]), 32'd0);
      check($sformatf("rst%0d_d_ack", k), 32'(d_ack_o[k]), 32'd0);
      check($sformatf("rst%0d_i_rdata", k), i_rdata_o[k], 32'd0);
      check($sformatf("rst%0d_d_rdata", k), d_rdata_o[k], 32'd0);
      check($sformatf("rst%0d_busy", k), 32'(busy_o[k]), 32'd0);
      check($sformatf("rst%0d_mem_re_we", k), {30'd0, mem_re_o[k], mem_we_o[k]}, 32'd0);
      check($sformatf("rst%0d_mem_addr", k), 32'(mem_addr_o[k]), 32'd0);
    end
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;

    // Table of single accesses on the ACCESS_CYCLES=1 instance
    for (int v = 0; v < 7; v++) begin
      access(0, vecs[v].port_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
             vecs[v].exp_rdata, 1, $sformatf("vec%0d", v));
    end

    // Round robin after reset: both ports request continuously -> I, D, I, D
    rst_n_s[0] = 1'b0;
    tick();
    rst_n_s[0] = 1'b1;
    i_req_s[0] = 1'b1; i_addr_s[0] = 8'h10;
    d_req_s[0] = 1'b1; d_we_s[0] = 1'b0; d_addr_s[0] = 8'h30;
    n_ack = 0;
    n = 0;
    stray = 0;
    while (n < 30 && n_ack < 4) begin
      tick();
      n++;
      if (i_ack_o[0] && d_ack_o[0]) stray++;
      if (i_ack_o[0]) begin
        ord[n_ack] = 0; t_ack[n_ack] = n; rd[n_ack] = i_rdata_o[0]; n_ack++;
      end else if (d_ack_o[0]) begin
        ord[n_ack] = 1; t_ack[n_ack] = n; rd[n_ack] = d_rdata_o[0]; n_ack++;
      end
    end
    i_req_s[0] = 1'b0;
    d_req_s[0] = 1'b0;
    check("rr_ack_count", 32'(n_ack), 32'd4);
    check("rr_simultaneous_acks", 32'(stray), 32'd0);
    for (int a = 0; a < n_ack; a++) begin
      check($sformatf("rr%0d_port", a), 32'(ord[a]), 32'(a % 2));
      check($sformatf("rr%0d_cycle", a), 32'(t_ack[a]), 32'(2 + 3 * a));
      check($sformatf("rr%0d_rdata", a), rd[a], (a % 2 == 0) ? 32'hA5A5A5A5 : 32'hDEADBEEF);
      $display("txn rr%0d: port=%s cycle=%0d rdata=0x%08h", a, ord[a] ? "D" : "I", t_ack[a], rd[a]);
    end
    tick();

    // ACCESS_CYCLES=4: single D read
    access(1, 1'b1, 1'b0, 8'h40, 32'h0, 32'hCAFEF00D, 4, "b_d_read");

    // Reset during the second BUSY cycle aborts the access
    tick();
    d_req_s[1] = 1'b1; d_we_s[1] = 1'b0; d_addr_s[1] = 8'h44;
    tick();
    check("abort_busy_cycle1_re", 32'(mem_re_o[1]), 32'd1);
    tick();
    rst_n_s[1] = 1'b0;
    d_req_s[1] = 1'b0;
    tick();
    check("abort_busy", 32'(busy_o[1]), 32'd0);
    check("abort_mem_re", 32'(mem_re_o[1]), 32'd0);
    check("abort_mem_we", 32'(mem_we_o[1]), 32'd0);
    check("abort_d_ack", 32'(d_ack_o[1]), 32'd0);
    check("abort_d_rdata", d_rdata_o[1], 32'd0);
    rst_n_s[1] = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (d_ack_o[1] || i_ack_o[1] || mem_re_o[1] || mem_we_o[1] || busy_o[1]) stray++;
    end
    check("abort_no_activity", 32'(stray), 32'd0);
    $display("txn abort: dut1 reset in second BUSY cycle, activity_after=%0d", stray);
    access(1, 1'b0, 1'b0, 8'h44, 32'h0, 32'h11112222, 4, "b_i_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
